// File: rtl/conv_sequencer.sv
// conv_sequencer -- frame-level controller for the convolve datapath.
//
// One frame is sequenced as: datapath clear, K*K kernel load (from the host
// stream or from a local replay cache), one priming shift write, then a
// W*H raster pixel stream, a short drain and a one-cycle done pulse. Every
// datapath result is tagged (valid/row/col) through a PIPE_LAT-deep delay
// line so that only interior, non-wrapped windows are reported.
//
// Optional feature macro: CONV_KERNEL_CACHE_EN
//   defined   : K*K x BITS cache captured during KLOAD; kernel_reload=0 with a
//               valid cache replays it (KREPLAY) instead of using the k_* stream.
//   undefined : no cache; kernel_reload is ignored and KLOAD is always used.
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   start, kernel_reload           frame request (IDLE only) and kernel source
//   abort                          synchronous frame abort (non-IDLE states)
//   k_valid/k_data/k_ready         kernel word stream, row-major
//   px_valid/px_data/px_ready      pixel stream, raster order
//   conv_reset                     synchronous clear to the datapath
//   conv_kernel_we/data            kernel write port of the datapath
//   conv_shift_we/conv_img_data    pixel shift port of the datapath
//   conv_pixel                     datapath result (img_output)
//   out_valid/pixel/row/col        tagged result stream (window top-left)
//   busy, done, underrun           status (done: 1-cycle pulse, underrun sticky)
//   dbg_state                      current FSM state
//
// Handshake rule for k_* and px_*: a word transfers on the rising edge at
// which valid and ready are both high; that same edge is the one at which the
// matching conv_*_we is high, so the datapath consumes the word directly.
// k_valid low stalls KLOAD. The pixel stream never stalls: px_ready is high
// for every STREAM cycle and a missing word is written as 0 (underrun).

module conv_sequencer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 128,
  parameter int IMG_HEIGHT  = 128,
  parameter int PIPE_LAT    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kernel_reload,
  input  logic            abort,
  input  logic            k_valid,
  input  logic [BITS-1:0] k_data,
  output logic            k_ready,
  input  logic            px_valid,
  input  logic [BITS-1:0] px_data,
  output logic            px_ready,
  output logic            conv_reset,
  output logic            conv_kernel_we,
  output logic [BITS-1:0] conv_kernel_data,
  output logic            conv_shift_we,
  output logic [BITS-1:0] conv_img_data,
  input  logic [BITS-1:0] conv_pixel,
  output logic            out_valid,
  output logic [BITS-1:0] out_pixel,
  output logic [7:0]      out_row,
  output logic [7:0]      out_col,
  output logic            busy,
  output logic            done,
  output logic            underrun,
  output logic [3:0]      dbg_state
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KW = (KK > 1) ? $clog2(KK) : 1;
  localparam int CW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(KK - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_LENGTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [7:0]    K_M1   = 8'(KERNEL_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLR     = 4'd1,
    S_KLOAD   = 4'd2,
    S_KREPLAY = 4'd3,
    S_PRIME   = 4'd4,
    S_STREAM  = 4'd5,
    S_DRAIN   = 4'd6,
    S_DONE    = 4'd7,
    S_ABORT   = 4'd8
  } state_t;

  typedef struct packed {
    logic       v;
    logic [7:0] row;
    logic [7:0] col;
  } tag_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   kidx_q, kidx_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            underrun_q, underrun_d;
  tag_t            tag_q [PIPE_LAT];
  tag_t            tag_d [PIPE_LAT];
  tag_t            new_tag;
  logic            flush;
  logic            clr_st;
  logic            use_replay;
  logic [BITS-1:0] cache_rd;
  logic [7:0]      row8, col8;

  assign row8 = 8'(row_q);
  assign col8 = 8'(col_q);

`ifdef CONV_KERNEL_CACHE_EN
  logic [BITS-1:0] cache_q [KK];
  logic [BITS-1:0] cache_d [KK];
  logic            cache_valid_q, cache_valid_d;
  logic            reload_q, reload_d;
  logic            cache_we;

  assign use_replay = cache_valid_q & ~reload_q;
  assign cache_rd   = cache_q[kidx_q];

  always_comb begin
    cache_d = cache_q;
    if (cache_we) cache_d[kidx_q] = k_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KK; i++) cache_q[i] <= '0;
      cache_valid_q <= 1'b0;
      reload_q      <= 1'b0;
    end else begin
      for (int i = 0; i < KK; i++) cache_q[i] <= cache_d[i];
      cache_valid_q <= cache_valid_d;
      reload_q      <= reload_d;
    end
  end
`else
  logic unused_reload;
  assign unused_reload = kernel_reload;
  assign use_replay    = 1'b0;
  assign cache_rd      = '0;
`endif

  always_comb begin
    state_d          = state_q;
    kidx_d           = kidx_q;
    col_d            = col_q;
    row_d            = row_q;
    dcnt_d           = dcnt_q;
    underrun_d       = underrun_q;
    k_ready          = 1'b0;
    px_ready         = 1'b0;
    conv_kernel_we   = 1'b0;
    conv_kernel_data = '0;
    conv_shift_we    = 1'b0;
    conv_img_data    = '0;
    new_tag          = '0;
    flush            = 1'b0;
    clr_st           = 1'b0;
    done             = 1'b0;
`ifdef CONV_KERNEL_CACHE_EN
    cache_we         = 1'b0;
    cache_valid_d    = cache_valid_q;
    reload_d         = reload_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLR;
          underrun_d = 1'b0;
`ifdef CONV_KERNEL_CACHE_EN
          reload_d   = kernel_reload;
`endif
        end
      end
      S_CLR: begin
        clr_st  = 1'b1;
        kidx_d  = '0;
        state_d = use_replay ? S_KREPLAY : S_KLOAD;
      end
      S_KLOAD: begin
        k_ready = 1'b1;
        if (k_valid) begin
          conv_kernel_we   = 1'b1;
          conv_kernel_data = k_data;
`ifdef CONV_KERNEL_CACHE_EN
          cache_we         = 1'b1;
`endif
          if (kidx_q == K_LAST) begin
            kidx_d  = '0;
            state_d = S_PRIME;
`ifdef CONV_KERNEL_CACHE_EN
            cache_valid_d = 1'b1;
`endif
          end else begin
            kidx_d = kidx_q + KW'(1);
          end
        end
      end
      S_KREPLAY: begin
        conv_kernel_we   = 1'b1;
        conv_kernel_data = cache_rd;
        if (kidx_q == K_LAST) begin
          kidx_d  = '0;
          state_d = S_PRIME;
        end else begin
          kidx_d = kidx_q + KW'(1);
        end
      end
      S_PRIME: begin
        // Dummy zero write: aligns the datapath fill counter with pixel 0.
        conv_shift_we = 1'b1;
        row_d         = '0;
        col_d         = '0;
        state_d       = S_STREAM;
      end
      S_STREAM: begin
        px_ready      = 1'b1;
        conv_shift_we = 1'b1;
        if (px_valid) conv_img_data = px_data;
        else          underrun_d    = 1'b1;
        // Tag names the window whose bottom-right pixel is being written.
        if ((row8 >= K_M1) && (col8 >= K_M1)) begin
          new_tag.v   = 1'b1;
          new_tag.row = row8 - K_M1;
          new_tag.col = col8 - K_M1;
        end
        if (col_q == C_LAST) begin
          col_d = '0;
          if (row_q == R_LAST) begin
            row_d   = '0;
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          dcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        clr_st  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything the current state would do this cycle:
    // no transfer is accepted, the delay line is emptied and no done fires.
    if (abort && (state_q != S_IDLE)) begin
      state_d          = S_ABORT;
      flush            = 1'b1;
      k_ready          = 1'b0;
      px_ready         = 1'b0;
      conv_kernel_we   = 1'b0;
      conv_kernel_data = '0;
      conv_shift_we    = 1'b0;
      conv_img_data    = '0;
      new_tag          = '0;
      done             = 1'b0;
      underrun_d       = underrun_q;
      kidx_d           = '0;
      row_d            = '0;
      col_d            = '0;
      dcnt_d           = '0;
`ifdef CONV_KERNEL_CACHE_EN
      cache_we         = 1'b0;
      // A partially overwritten cache must not be replayed.
      if (state_q == S_KLOAD) cache_valid_d = 1'b0;
`endif
    end
  end

  always_comb begin
    tag_d[0] = new_tag;
    for (int i = 1; i < PIPE_LAT; i++) tag_d[i] = tag_q[i-1];
    if (flush) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      kidx_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dcnt_q     <= '0;
      underrun_q <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      kidx_q     <= kidx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dcnt_q     <= dcnt_d;
      underrun_q <= underrun_d;
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  // The datapath is held in reset for as long as the sequencer is.
  assign conv_reset = clr_st | ~reset_n;
  assign out_valid  = tag_q[PIPE_LAT-1].v;
  assign out_row    = tag_q[PIPE_LAT-1].row;
  assign out_col    = tag_q[PIPE_LAT-1].col;
  assign out_pixel  = out_valid ? conv_pixel : '0;
  assign busy       = (state_q != S_IDLE);
  assign underrun   = underrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;
  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PL   = 2;
  localparam int KK   = K * K;
  localparam int NPIX = W * H;
  localparam int NOUT = (H - K + 1) * (W - K + 1);
  localparam int EW   = 8 + 8 + BITS;

  logic            clk, reset_n, start, kernel_reload, abort;
  logic            k_valid, k_ready, px_valid, px_ready;
  logic [BITS-1:0] k_data, px_data;
  logic            conv_reset, conv_kernel_we, conv_shift_we;
  logic [BITS-1:0] conv_kernel_data, conv_img_data, conv_pixel;
  logic            out_valid, busy, done, underrun;
  logic [BITS-1:0] out_pixel;
  logic [7:0]      out_row, out_col;
  logic [3:0]      dbg_state;

  conv_sequencer #(
    .BITS(BITS), .KERNEL_SIZE(K), .IMG_LENGTH(W), .IMG_HEIGHT(H), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kernel_reload(kernel_reload),
    .abort(abort), .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .conv_reset(conv_reset), .conv_kernel_we(conv_kernel_we),
    .conv_kernel_data(conv_kernel_data), .conv_shift_we(conv_shift_we),
    .conv_img_data(conv_img_data), .conv_pixel(conv_pixel),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_row(out_row),
    .out_col(out_col), .busy(busy), .done(done), .underrun(underrun),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  int wr_cnt, kw_cnt, n_out, done_cnt, done_base;
  int first_valid_cyc, last_valid_cyc, wr22_cyc, stream_start, done_cyc;
  int kern[KK], model_kern[KK], cached_kern[KK];
  int img[NPIX], f1_img[NPIX];
  bit cache_ok;
  int fw;
  bit ab;
  int nout_frozen;

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, req, $time);
    end
  endtask

  function automatic logic [BITS-1:0] clip(input int s);
    if (s > 255) return BITS'(255);
    if (s < 0) return '0;
    return BITS'(s);
  endfunction

  // ---------------- datapath stand-in ----------------
  // Ideal convolve: result of the window ending at the latest shift write,
  // presented PL cycles after that write.
  logic [BITS-1:0] dp_hist[$];
  logic [BITS-1:0] dp_kern[$];
  logic [BITS-1:0] dp_pipe[PL];

  function automatic logic [BITS-1:0] dp_window();
    int n, s;
    n = dp_hist.size();
    if (n < (K-1)*W + K || dp_kern.size() < KK) return '0;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += int'(dp_kern[i*K+j]) * int'(dp_hist[n-1-(K-1-i)*W-(K-1-j)]);
    return clip(s);
  endfunction

  always @(posedge clk) begin
    if (conv_reset) begin
      dp_hist.delete();
      dp_kern.delete();
      dp_pipe[0] <= '0;
    end else begin
      if (conv_kernel_we) dp_kern.push_back(conv_kernel_data);
      if (conv_shift_we) begin
        dp_hist.push_back(conv_img_data);
        dp_pipe[0] <= dp_window();
      end else begin
        dp_pipe[0] <= '0;
      end
    end
    for (int i = 1; i < PL; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign conv_pixel = dp_pipe[PL-1];

  // ---------------- reference model ----------------
  // Expected interior windows in raster order, from the intended frame image.
  task automatic push_expected(input int drop_at);
    int s, p, v;
    for (int r = 0; r <= H - K; r++)
      for (int c = 0; c <= W - K; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            p = (r + i) * W + c + j;
            v = (p == drop_at) ? 0 : img[p];
            s += model_kern[i*K+j] * v;
          end
        exp_q.push_back({8'(r), 8'(c), clip(s)});
      end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset_n) begin
      if (conv_shift_we) begin
        wr_cnt++;
        if (wr_cnt == 2*W + 4) wr22_cyc = cyc;
      end
      if (conv_kernel_we) kw_cnt++;
      if (done) done_cnt++;
      if (out_valid) begin
        n_out++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        last_valid_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL out_unexpected: got row=%0d col=%0d pix=%0d required no output",
                   out_row, out_col, out_pixel);
        end else begin
          e = exp_q.pop_front();
          if ({out_row, out_col, out_pixel} !== e) begin
            n_errors++;
            $display("FAIL out_stream: got row=%0d col=%0d pix=%0d required row=%0d col=%0d pix=%0d",
                     out_row, out_col, out_pixel, e[EW-1 -: 8], e[EW-9 -: 8], e[BITS-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input bit reload);
    start = 1'b1;
    kernel_reload = reload;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clr_pulse", conv_reset, 1);
    chk("clr_underrun_clear", underrun, 0);
    chk("clr_busy", busy, 1);
    wr_cnt = 0; kw_cnt = 0; n_out = 0;
    first_valid_cyc = -1; last_valid_cyc = -1; wr22_cyc = -1;
    done_base = done_cnt;
  endtask

  task automatic send_kernel(input int n, output int first_wait);
    int w;
    first_wait = -1;
    for (int idx = 0; idx < n; idx++) begin
      if (idx > 0 && $urandom_range(0, 2) == 0) begin
        k_valid = 1'b0;
        @(posedge clk); #1;
      end
      k_valid = 1'b1;
      k_data  = BITS'(kern[idx]);
      w = 0;
      while (!k_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (idx == 0) first_wait = w;
      if (!k_ready) begin
        chk("k_ready_timeout", 0, 1);
        k_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    k_valid = 1'b0;
  endtask

  task automatic send_pixels(input int drop_at, input int abort_at, output bit aborted);
    int w, stalls;
    aborted = 1'b0;
    px_valid = 1'b0;
    w = 0;
    while (!px_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("px_ready_seen", px_ready, 1);
    stream_start = cyc;
    stalls = 0;
    for (int n = 0; n < NPIX; n++) begin
      if (n == abort_at) begin
        px_valid = 1'b0;
        abort = 1'b1;
        start = 1'b1;  // abort wins over a simultaneous start
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (!px_ready) stalls++;
      px_valid = (n != drop_at);
      px_data  = BITS'(img[n]);
      start    = (n == 10);  // ignored outside IDLE
      @(posedge clk); #1;
    end
    px_valid = 1'b0;
    start = 1'b0;
    if (!aborted) chk("stream_stalls", stalls, 0);
  endtask

  task automatic finish_frame();
    int w;
    w = 0;
    while (!done && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_seen", done, 1);
    done_cyc = cyc;
    chk("frame_stream_to_done", done_cyc - stream_start, NPIX + PL);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("done_count", done_cnt - done_base, 1);
    chk("out_count", n_out, NOUT);
    chk("exp_empty", exp_q.size(), 0);
    chk("kernel_writes", kw_cnt, KK);
    chk("first_valid_latency", first_valid_cyc - wr22_cyc, PL);
    chk("last_valid_in_drain", done_cyc - last_valid_cyc, 1);
  endtask

  task automatic note_load();
    cache_ok = 1'b1;
    for (int i = 0; i < KK; i++) cached_kern[i] = kern[i];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; kernel_reload = 1'b0; abort = 1'b0;
    k_valid = 1'b0; k_data = '0; px_valid = 1'b0; px_data = '0;
    cache_ok = 1'b0; done_cnt = 0; done_base = 0;
    wr_cnt = 0; kw_cnt = 0; n_out = 0;
    first_valid_cyc = -1; last_valid_cyc = -1; wr22_cyc = -1;
    #1;
    chk("rst_conv_reset", conv_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_out", {out_valid, out_row, out_col, out_pixel}, 0);
    chk("rst_handshakes", {k_ready, px_ready, conv_kernel_we, conv_shift_we}, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_conv_reset", conv_reset, 0);
    chk("idle_busy0", busy, 0);

    // Frame 1: identity kernel, pixel = 8r+c
    for (int i = 0; i < KK; i++) kern[i] = (i == KK/2) ? 1 : 0;
    for (int p = 0; p < NPIX; p++) begin
      img[p] = 8 * (p / W) + (p % W);
      f1_img[p] = img[p];
    end
    model_kern = kern;
    start_frame(1'b1);
    send_kernel(KK, fw);
    chk("start_to_kload", fw, 1);
    note_load();
    push_expected(-1);
    send_pixels(-1, -1, ab);
    finish_frame();

    // Frame 2: box kernel, saturated result
    for (int i = 0; i < KK; i++) kern[i] = 1;
    for (int p = 0; p < NPIX; p++) img[p] = 100;
    model_kern = kern;
    start_frame(1'b1);
    send_kernel(KK, fw);
    note_load();
    push_expected(-1);
    send_pixels(-1, -1, ab);
    finish_frame();

    // Frame 3: random data with a dropped pixel
    for (int i = 0; i < KK; i++) kern[i] = $urandom_range(0, 3);
    for (int p = 0; p < NPIX; p++) img[p] = $urandom_range(0, 63);
    model_kern = kern;
    start_frame(1'b1);
    send_kernel(KK, fw);
    note_load();
    push_expected(20);
    send_pixels(20, -1, ab);
    finish_frame();
    chk("underrun_set", underrun, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("underrun_sticky", underrun, 1);

    // Frame 4: identity kernel, abort mid-stream
    for (int i = 0; i < KK; i++) kern[i] = (i == KK/2) ? 1 : 0;
    for (int p = 0; p < NPIX; p++) img[p] = $urandom_range(0, 255);
    model_kern = kern;
    start_frame(1'b1);
    send_kernel(KK, fw);
    note_load();
    push_expected(-1);
    send_pixels(-1, 30, ab);
    chk("abort_taken", ab, 1);
    chk("abort_conv_reset", conv_reset, 1);
    exp_q.delete();
    nout_frozen = n_out;
    @(posedge clk); #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_reset_one_cycle", conv_reset, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - done_base, 0);
    chk("abort_no_outputs", n_out, nout_frozen);

`ifdef CONV_KERNEL_CACHE_EN
    // Frame 5: replay cached kernel, host kernel stream idle
    for (int p = 0; p < NPIX; p++) img[p] = f1_img[p];
    model_kern = cached_kern;
    chk("cache_model_valid", cache_ok, 1);
    start_frame(1'b0);
    k_valid = 1'b0;
    push_expected(-1);
    send_pixels(-1, -1, ab);
    finish_frame();
`else
    // Frame 5: without a cache the frame waits for the host kernel stream
    start_frame(1'b0);
    k_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("nocache_kload_wait", {busy, k_ready, conv_kernel_we}, 3'b110);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("nocache_abort_reset", conv_reset, 1);
    @(posedge clk); #1;
    chk("nocache_abort_idle", busy, 0);
`endif

    // Frame 6: asynchronous reset during kernel load
    for (int i = 0; i < KK; i++) kern[i] = $urandom_range(0, 3);
    start_frame(1'b1);
    send_kernel(4, fw);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_conv_reset", conv_reset, 1);
    chk("arst_busy", busy, 0);
    chk("arst_handshakes", {k_ready, px_ready, conv_kernel_we, conv_shift_we}, 0);
    chk("arst_status", {done, underrun, out_valid}, 0);
    cache_ok = 1'b0;
    exp_q.delete();
    k_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Cache is invalid after reset: reload=0 still takes the host stream
    for (int p = 0; p < NPIX; p++) img[p] = $urandom_range(0, 63);
    model_kern = kern;
    start_frame(1'b0);
    k_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_kload", k_ready, 1);
    send_kernel(KK, fw);
    note_load();
    push_expected(-1);
    send_pixels(-1, -1, ab);
    finish_frame();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
